// File: rtl/vga_term_writer_pkg.sv
// Shared constants for the VGA character-terminal writer:
// screen geometry, ASCII codes, FSM encoding and char-buffer address layout.
package vga_term_writer_pkg;
    localparam int COLS = 70;
    localparam int ROWS = 30;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] BS    = 8'h08;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_PUT   = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    localparam int ADDR_COL_LSB = 0;
    localparam int ADDR_COL_W   = 7;
    localparam int ADDR_ROW_LSB = 7;
    localparam int ADDR_ROW_W   = 5;

    // Same layout as the display read address: {4'b0000, row[4:0], col[6:0]}.
    function automatic logic [15:0] make_addr(input logic [4:0] row, input logic [6:0] col);
        logic [15:0] a;
        a = '0;
        a[ADDR_ROW_LSB +: ADDR_ROW_W] = row;
        a[ADDR_COL_LSB +: ADDR_COL_W] = col;
        return a;
    endfunction
endpackage

// File: rtl/term_cursor.sv
// Cursor and scroll-offset registers plus logical-to-physical row mapping.
// Updates take effect on the next clk_50m edge; no flow control of its own.
module term_cursor #(
    parameter int COLS = 70,
    parameter int ROWS = 30
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic       adv_i,
    input  logic       nl_i,
    input  logic       bs_i,
    output logic [6:0] cur_h_o,
    output logic [4:0] cur_v_o,
    output logic [4:0] line_offset_o,
    output logic [4:0] phys_row_o,
    output logic [4:0] nl_phys_row_o,
    output logic [4:0] bs_phys_row_o
);
    import vga_term_writer_pkg::*;

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [5:0] ROWS_W   = 6'(ROWS);

    logic [6:0] h_q, h_d;
    logic [4:0] v_q, v_d;
    logic [4:0] off_q, off_d;

    // Both operands are below ROWS, so one conditional subtract is a full mod.
    function automatic logic [4:0] wrap_row(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= ROWS_W) s = s - ROWS_W;
        return s[4:0];
    endfunction

    assign phys_row_o    = wrap_row(off_q, v_q);
    // When scrolling, the new bottom row lands on the old offset row.
    assign nl_phys_row_o = (v_q == LAST_ROW) ? off_q : wrap_row(off_q, v_q + 5'd1);
    assign bs_phys_row_o = wrap_row(off_q, v_q - 5'd1);

    always_comb begin
        h_d   = h_q;
        v_d   = v_q;
        off_d = off_q;
        if (nl_i) begin
            h_d = '0;
            if (v_q != LAST_ROW) v_d = v_q + 5'd1;
            else off_d = (off_q == LAST_ROW) ? 5'd0 : off_q + 5'd1;
        end else if (adv_i) begin
            if (h_q != LAST_COL) h_d = h_q + 7'd1;
        end else if (bs_i) begin
            if (h_q != 7'd0) begin
                h_d = h_q - 7'd1;
            end else if (v_q != 5'd0) begin
                v_d = v_q - 5'd1;
                h_d = LAST_COL;
            end
        end
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            h_q   <= '0;
            v_q   <= '0;
            off_q <= '0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            off_q <= off_d;
        end
    end

    assign cur_h_o       = h_q;
    assign cur_v_o       = v_q;
    assign line_offset_o = off_q;
endmodule

// File: rtl/vga_term_writer.sv
// Byte stream to scrolling char-buffer writer; a write appears the cycle after acceptance.
// in_ready is high only in IDLE, so each PUT/CLEAR/INIT stalls the input.
module vga_term_writer #(
    parameter int COLS = vga_term_writer_pkg::COLS,
    parameter int ROWS = vga_term_writer_pkg::ROWS
) (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_char,
    output logic        in_ready,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [6:0]  cur_h,
    output logic [4:0]  cur_v,
    output logic [4:0]  line_offset,
    output logic        busy
);
    import vga_term_writer_pkg::*;

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    logic [1:0]  state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic        last_q, last_d;
    logic        put_bs_q, put_bs_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        adv, nl, bs, do_nl, printable;
    logic [4:0]  phys_row, nl_phys_row, bs_phys_row;

    term_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
        .clk_50m       (clk_50m),
        .rst           (rst),
        .adv_i         (adv),
        .nl_i          (nl),
        .bs_i          (bs),
        .cur_h_o       (cur_h),
        .cur_v_o       (cur_v),
        .line_offset_o (line_offset),
        .phys_row_o    (phys_row),
        .nl_phys_row_o (nl_phys_row),
        .bs_phys_row_o (bs_phys_row)
    );

    assign printable = (in_char >= SPACE) && (in_char <= 8'h7E);

    // Write-port registers are loaded on the edge that enters a writing cycle,
    // so wr_en is high exactly during the INIT/PUT/CLEAR cycles that write.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        last_d    = last_q;
        put_bs_d  = put_bs_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        adv       = 1'b0;
        nl        = 1'b0;
        bs        = 1'b0;
        do_nl     = 1'b0;
        case (state_q)
            ST_INIT, ST_CLEAR: begin
                if (last_q) begin
                    state_d = ST_IDLE;
                    last_d  = 1'b0;
                    col_d   = '0;
                    row_d   = '0;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = make_addr(row_q, col_q);
                    wr_data_d = SPACE;
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (state_q == ST_CLEAR || row_q == LAST_ROW) last_d = 1'b1;
                        else row_d = row_q + 5'd1;
                    end else begin
                        col_d = col_q + 7'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (in_valid) begin
                    if (printable) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = make_addr(phys_row, cur_h);
                        wr_data_d = in_char;
                        put_bs_d  = 1'b0;
                        state_d   = ST_PUT;
                    end else if (in_char == LF || in_char == CR) begin
                        do_nl = 1'b1;
                    end else if (in_char == BS && (cur_h != 7'd0 || cur_v != 5'd0)) begin
                        bs        = 1'b1;
                        wr_en_d   = 1'b1;
                        wr_addr_d = (cur_h != 7'd0) ? make_addr(phys_row, cur_h - 7'd1)
                                                    : make_addr(bs_phys_row, LAST_COL);
                        wr_data_d = SPACE;
                        put_bs_d  = 1'b1;
                        state_d   = ST_PUT;
                    end
                end
            end
            ST_PUT: begin
                if (!put_bs_q && cur_h == LAST_COL) begin
                    do_nl = 1'b1;
                end else begin
                    adv     = !put_bs_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
        // Newline issues column 0 of the target row immediately; CLEAR continues from 1.
        if (do_nl) begin
            nl        = 1'b1;
            state_d   = ST_CLEAR;
            row_d     = nl_phys_row;
            col_d     = 7'd1;
            wr_en_d   = 1'b1;
            wr_addr_d = make_addr(nl_phys_row, 7'd0);
            wr_data_d = SPACE;
        end
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INIT;
            col_q     <= '0;
            row_q     <= '0;
            last_q    <= 1'b0;
            put_bs_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            last_q    <= last_d;
            put_bs_q  <= put_bs_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
endmodule

// File: tb/tb_vga_term_writer.sv
// Directed bench for vga_term_writer: stimulus queues expected writes,
// a negedge monitor pops and compares every wr_en pulse.
module tb_vga_term_writer;
    logic        clk_50m = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_char;
    logic        in_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  cur_h;
    logic [4:0]  cur_v;
    logic [4:0]  line_offset;
    logic        busy;

    int          total  = 0;
    int          passed = 0;
    logic [23:0] exp_q[$];
    logic [23:0] mon_e;

    vga_term_writer #(.COLS(70), .ROWS(30)) dut (
        .clk_50m     (clk_50m),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_char     (in_char),
        .in_ready    (in_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .cur_h       (cur_h),
        .cur_v       (cur_v),
        .line_offset (line_offset),
        .busy        (busy)
    );

    always #10 clk_50m = ~clk_50m;

    function automatic logic [15:0] ad(input int r, input int c);
        return 16'(r * 128 + c);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic push(input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic push_clear(input int r);
        for (int c = 0; c < 70; c++) push(ad(r, c), 8'h20);
    endtask

    task automatic push_init();
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 70; c++) push(ad(r, c), 8'h20);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!in_ready && n < 2500) begin
            @(negedge clk_50m);
            n++;
        end
        chk(name, 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] c);
        wait_idle("send_ready");
        in_char  = c;
        in_valid = 1'b1;
        @(negedge clk_50m);
        in_valid = 1'b0;
    endtask

    always @(negedge clk_50m) begin
        if (!rst && wr_en) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_write: got addr 0x%04h data 0x%02h, want no write",
                         wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write", 32'({wr_addr, wr_data}), 32'(mon_e));
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_en"},    32'(wr_en),       32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready),    32'd0);
        chk({tag, "_busy"},     32'(busy),        32'd1);
        chk({tag, "_cur_h"},    32'(cur_h),       32'd0);
        chk({tag, "_cur_v"},    32'(cur_v),       32'd0);
        chk({tag, "_offset"},   32'(line_offset), 32'd0);
        chk({tag, "_wr_addr"},  32'(wr_addr),     32'd0);
        chk({tag, "_wr_data"},  32'(wr_data),     32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_char  = 8'h00;
        repeat (3) @(negedge clk_50m);
        chk_reset_outputs("reset");

        push_init();
        rst = 1'b0;
        @(negedge clk_50m);
        chk("init_busy", 32'(busy), 32'd1);
        wait_idle("init_done");
        chk("init_all_written", 32'(exp_q.size()), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        push(16'h0000, 8'h41);
        send(8'h41);
        chk("A_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk_50m);
        chk("A_ready_back", 32'(in_ready), 32'd1);
        chk("A_cur_h", 32'(cur_h), 32'd1);
        chk("A_hold_addr", 32'(wr_addr), 32'h0000);
        chk("A_hold_data", 32'(wr_data), 32'h41);

        push(16'h0000, 8'h20);
        send(8'h08);
        wait_idle("bs1_idle");
        chk("bs1_cur_h", 32'(cur_h), 32'd0);

        for (int i = 0; i < 70; i++) begin
            push(ad(0, i), 8'(8'h30 + i));
            if (i == 69) push_clear(1);
            send(8'(8'h30 + i));
        end
        wait_idle("line_idle");
        chk("line_cur_h", 32'(cur_h), 32'd0);
        chk("line_cur_v", 32'(cur_v), 32'd1);
        chk("line_drained", 32'(exp_q.size()), 32'd0);

        push_clear(2);
        send(8'h0A);
        push_clear(3);
        send(8'h0D);
        wait_idle("crlf_idle");
        chk("crlf_cur_v", 32'(cur_v), 32'd3);

        push(ad(2, 69), 8'h20);
        send(8'h08);
        wait_idle("bs2_idle");
        chk("bs2_cur_h", 32'(cur_h), 32'd69);
        chk("bs2_cur_v", 32'(cur_v), 32'd2);

        push_clear(3);
        send(8'h0D);
        for (int v = 3; v < 29; v++) begin
            push_clear(v + 1);
            send(8'h0A);
        end
        wait_idle("bottom_idle");
        chk("bottom_cur_v", 32'(cur_v), 32'd29);
        chk("bottom_offset", 32'(line_offset), 32'd0);

        push_clear(0);
        send(8'h0A);
        wait_idle("scroll1_idle");
        chk("scroll1_offset", 32'(line_offset), 32'd1);
        chk("scroll1_cur_v", 32'(cur_v), 32'd29);
        chk("scroll1_drained", 32'(exp_q.size()), 32'd0);

        push_clear(1);
        send(8'h0A);
        wait_idle("scroll2_idle");
        chk("scroll2_offset", 32'(line_offset), 32'd2);

        push(16'h0080, 8'h5A);
        send(8'h5A);
        wait_idle("Z_idle");
        chk("Z_cur_h", 32'(cur_h), 32'd1);
        chk("Z_hold_addr", 32'(wr_addr), 32'h0080);

        push(16'h0080, 8'h20);
        send(8'h08);
        push(16'h0045, 8'h20);
        send(8'h08);
        wait_idle("bs3_idle");
        chk("bs3_cur_h", 32'(cur_h), 32'd69);
        chk("bs3_cur_v", 32'(cur_v), 32'd28);

        send(8'h7F);
        chk("ign_ready", 32'(in_ready), 32'd1);
        chk("ign_cur_h", 32'(cur_h), 32'd69);

        push_clear(1);
        send(8'h0A);
        repeat (10) @(negedge clk_50m);
        chk("midclear_busy", 32'(busy), 32'd1);
        #3 rst = 1'b1;
        #1 chk_reset_outputs("midreset");
        exp_q.delete();
        repeat (2) @(negedge clk_50m);
        push_init();
        rst = 1'b0;
        wait_idle("reinit_done");
        chk("reinit_all_written", 32'(exp_q.size()), 32'd0);

        send(8'h08);
        chk("bs00_ready", 32'(in_ready), 32'd1);
        chk("bs00_cur_h", 32'(cur_h), 32'd0);
        chk("bs00_cur_v", 32'(cur_v), 32'd0);
        repeat (5) @(negedge clk_50m);
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/vga_term_writer.md
VGA_TERM_WRITER -- requirements
Module: vga_term_writer

Interface
REQ-001 The module SHALL have the following parameters (name, default, meaning):
- COLS, 70, characters per line.
- ROWS, 30, lines per screen.
REQ-002 The module SHALL have the following ports (name, direction, width, meaning):
- clk_50m, in, 1, sole clock.
- rst, in, 1, reset; asynchronous, active-high.
- in_valid, in, 1, in_char is offered.
- in_char, in, 8, ASCII byte.
- in_ready, out, 1, byte is accepted when in_valid & in_ready.
- wr_en, out, 1, char-buffer write strobe.
- wr_addr, out, 16, {4'b0000, phys_row[4:0], col[6:0]}; same format as the display read address.
- wr_data, out, 8, byte written.
- cur_h, out, 7, cursor column (logical).
- cur_v, out, 5, cursor row (logical).
- line_offset, out, 5, physical row shown as logical row 0.
- busy, out, 1, high in any state other than IDLE.

Function
REQ-003 The state machine SHALL have four states: INIT, IDLE, PUT, CLEAR.
REQ-004 in_ready SHALL equal 1 only in IDLE.
REQ-005 Physical row SHALL be (line_offset + logical row) mod ROWS, using a compare-and-subtract; no divider.
REQ-006 INIT SHALL write 0x20 to all ROWS×COLS cells, one cell per cycle, row-major from (0,0), then go to IDLE. This takes 2100 cycles at default parameters.
REQ-007 Printable byte (0x20..0x7E) accepted in cycle N:
- PUT in cycle N+1: wr_en=1, wr_data=in_char, address = cursor.
- cur_h increments at the end of N+1.
- Return to IDLE at N+2, unless a wrap occurs.
REQ-008 If the printable byte is written at cur_h=COLS-1, the block SHALL perform the newline action (REQ-009) after the PUT cycle.
REQ-009 Newline action:
- cur_h←0.
- If cur_v<ROWS-1: cur_v++.
- Else: line_offset←(line_offset+1) mod ROWS and cur_v stays at ROWS-1.
- Then enter CLEAR for the new logical row.
REQ-010 CLEAR SHALL write 0x20 to columns 0..COLS-1 of the target physical row, one per cycle (70 cycles), then go to IDLE.
REQ-011 0x0A and 0x0D SHALL each trigger the newline action with no character write.
REQ-012 0x08 (backspace) SHALL behave as follows:
- cur_h>0: cur_h--.
- cur_h=0 and cur_v>0: cur_v--, cur_h←COLS-1.
- In both cases, one PUT cycle then writes 0x20 at the new cursor.
- At (0,0): consumed with no write and no cursor change; IDLE is held.
REQ-013 All other bytes SHALL be consumed and ignored, with in_ready remaining high.
REQ-014 wr_en SHALL be 0 in IDLE; wr_addr and wr_data SHALL hold their last values when wr_en=0.
REQ-015 line_offset SHALL wrap from ROWS-1 to 0; cur_h and cur_v SHALL never exceed COLS-1 and ROWS-1.
REQ-016 cur_h, cur_v and line_offset SHALL be registered outputs, updated only on clk_50m rising edges.

Reset
REQ-017 Asserting rst SHALL asynchronously set:
- state=INIT, wr_en=0, in_ready=0, busy=1.
- cur_h=0, cur_v=0, line_offset=0.
- wr_addr=0, wr_data=0, clear counters=0.
REQ-018 Reset asserted mid-PUT, CLEAR or INIT SHALL abort the operation. A full INIT SHALL restart on the first clock after release.

Structure
REQ-019 A shared package SHALL hold:
- COLS, ROWS.
- ASCII constants: SPACE=0x20, LF=0x0A, CR=0x0D, BS=0x08.
- The state encoding.
- The wr_addr field positions.
REQ-020 A single sub-module, term_cursor, SHALL own cur_h, cur_v, line_offset and the physical-row computation. The FSM and write-port logic SHALL stay in vga_term_writer.

Verification
REQ-021 Reset, then idle: exactly 2100 wr_en pulses with wr_data=0x20 covering all cells once; then in_ready=1.
REQ-022 Send 'A' (0x41) at (0,0): one cycle with wr_en=1, wr_addr=0x0000, wr_data=0x41; afterwards cur_h=1 and in_ready is low for exactly 1 cycle.
REQ-023 Send 70 printable bytes from (0,0): the last write has wr_addr=0x0045; then 70 clears of row 1 (0x0080..0x00C5); final cursor (0,1).
REQ-024 Issue LF at cur_v=29 with line_offset=0: afterwards line_offset=1, cur_v=29, and physical row 0 is cleared (wr_addr 0x0000..0x0045).
REQ-025 Backspace at (0,3): afterwards cursor (69,2) and one write of 0x20 to physical row 2, column 69. Backspace at (0,0): no wr_en pulse.
REQ-026 Assert rst in the middle of CLEAR: wr_en drops immediately, all outputs take their REQ-017 values, and the full 2100-cell INIT then reruns.
